// File: rtl/ecc_secded_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ecc_secded_pipe
//  Purpose  : Parametrised two-stage pipelined SEC-DED Hamming decoder with
//             valid/ready flow control and saturating error counters. Sits on
//             the read-return path between a protected SRAM and its consumer.
//
//  Parameters
//    DATA_W  data bits per word (8, 16, 32, 64)
//    CHK_W   check bits per word incl. overall parity (5, 6, 7, 8)
//    CNT_W   width of each error counter
//
//  Ports
//    clk, rst_n           clock / asynchronous active-low reset
//    in_valid, in_ready   input handshake
//    in_data, in_chk      received data and check bits; in_chk[i] (i<CHK_W-1)
//                         is the Hamming bit at position 2^i, in_chk[CHK_W-1]
//                         is overall parity
//    corr_en              1 = correct single-bit data errors, 0 = pass raw
//    out_valid, out_ready output handshake
//    out_data             corrected (or raw) data
//    out_sbe, out_dbe     single-bit / uncorrectable error flags
//    out_syn              Hamming syndrome (error position)
//    cnt_clr              synchronous clear of both counters
//    sbe_cnt, dbe_cnt     saturating counts of delivered SBE / DBE words
//
//  Optional build macro: ECC_ERR_INJECT_EN
//    Adds inj_en / inj_mask; when inj_en is high at input accept the mask is
//    XORed onto {in_chk, in_data} before the syndrome is formed.
//
//  Revision : 1.0  initial release
// ============================================================================
module ecc_secded_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [CHK_W-1:0]        in_chk,
  input  logic                    corr_en,
`ifdef ECC_ERR_INJECT_EN
  input  logic                    inj_en,
  input  logic [DATA_W+CHK_W-1:0] inj_mask,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_sbe,
  output logic                    out_dbe,
  output logic [CHK_W-2:0]        out_syn,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        sbe_cnt,
  output logic [CNT_W-1:0]        dbe_cnt
);

  // Number of Hamming check bits and highest codeword position.
  localparam int HC     = CHK_W - 1;
  localparam int NPOS   = DATA_W + CHK_W - 1;
  localparam int WORD_W = DATA_W + CHK_W;

  localparam logic [HC-1:0]    c_npos    = NPOS[HC-1:0];
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Codeword position of data bit j: the j-th non-power-of-two position,
  // counting upward from 1.
  function automatic int data_pos(input int j);
    int k;
    int res;
    k   = 0;
    res = 0;
    for (int p = 1; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        if ((k == j) && (res == 0)) begin
          res = p;
        end
        k = k + 1;
      end
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Input word (optionally with injected errors)
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] w_word;
  logic [DATA_W-1:0] w_rx_data;
  logic [CHK_W-1:0]  w_rx_chk;

`ifdef ECC_ERR_INJECT_EN
  assign w_word = {in_chk, in_data} ^ (inj_en ? inj_mask : {WORD_W{1'b0}});
`else
  assign w_word = {in_chk, in_data};
`endif

  assign w_rx_data = w_word[DATA_W-1:0];
  assign w_rx_chk  = w_word[WORD_W-1:DATA_W];

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [HC-1:0]     s1_syn_q,   s1_syn_d;
  logic              s1_par_q,   s1_par_d;
  logic              s1_corr_q,  s1_corr_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic              s2_sbe_q,   s2_sbe_d;
  logic              s2_dbe_q,   s2_dbe_d;
  logic [HC-1:0]     s2_syn_q,   s2_syn_d;

  logic [CNT_W-1:0]  sbe_cnt_q,  sbe_cnt_d;
  logic [CNT_W-1:0]  dbe_cnt_q,  dbe_cnt_d;

  // --------------------------------------------------------------------------
  // Per-data-bit position constants: syndrome contribution on the input side
  // and correction select on the stage-2 side.
  // --------------------------------------------------------------------------
  logic [HC-1:0]     w_dterm [DATA_W];
  logic [DATA_W-1:0] w_flip;

  for (genvar j = 0; j < DATA_W; j++) begin : g_dpos
    localparam int            P  = data_pos(j);
    localparam logic [HC-1:0] PV = P[HC-1:0];
    assign w_dterm[j] = w_rx_data[j] ? PV : {HC{1'b0}};
    // A check-bit or out-of-range syndrome matches no data position, so the
    // correction vector is naturally all-zero in those cases.
    assign w_flip[j]  = (s1_syn_q == PV);
  end

  // Syndrome = XOR of positions of all set bits. Check bit i sits at 2^i, so
  // its contribution is simply bit i of the syndrome.
  logic [HC-1:0] w_syn;
  logic          w_par;

  always_comb begin
    w_syn = w_rx_chk[HC-1:0];
    for (int j = 0; j < DATA_W; j++) begin
      w_syn = w_syn ^ w_dterm[j];
    end
  end

  assign w_par = ^w_word;

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic w_s2_adv;
  logic w_s1_fire;
  logic w_in_fire;
  logic w_out_fire;

  assign w_s2_adv   = !s2_valid_q | out_ready;
  assign w_s1_fire  = s1_valid_q & w_s2_adv;
  assign in_ready   = !s1_valid_q | w_s2_adv;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = s2_valid_q & out_ready;

  // --------------------------------------------------------------------------
  // Stage-2 classification from stage-1 registers
  // --------------------------------------------------------------------------
  logic              w_syn_nz;
  logic              w_in_range;
  logic              w_sbe;
  logic              w_dbe;
  logic [DATA_W-1:0] w_corr_data;

  assign w_syn_nz    = |s1_syn_q;
  assign w_in_range  = (s1_syn_q <= c_npos);
  assign w_sbe       = s1_par_q & w_in_range;
  assign w_dbe       = (s1_par_q & !w_in_range) | (!s1_par_q & w_syn_nz);
  assign w_corr_data = s1_data_q ^ ({DATA_W{w_sbe & s1_corr_q}} & w_flip);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = w_in_fire | (s1_valid_q & !w_s2_adv);
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    s1_corr_d  = s1_corr_q;
    if (w_in_fire) begin
      s1_data_d = w_rx_data;
      s1_syn_d  = w_syn;
      s1_par_d  = w_par;
      s1_corr_d = corr_en;
    end
  end

  always_comb begin
    s2_valid_d = w_s2_adv ? s1_valid_q : s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sbe_d   = s2_sbe_q;
    s2_dbe_d   = s2_dbe_q;
    s2_syn_d   = s2_syn_q;
    // Output fields only change when a new word moves in, so they stay
    // stable while the consumer stalls.
    if (w_s1_fire) begin
      s2_data_d = w_corr_data;
      s2_sbe_d  = w_sbe;
      s2_dbe_d  = w_dbe;
      s2_syn_d  = s1_syn_q;
    end
  end

  always_comb begin
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (cnt_clr) begin
      sbe_cnt_d = {CNT_W{1'b0}};
      dbe_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (w_out_fire && s2_sbe_q && (sbe_cnt_q != c_cnt_max)) begin
        sbe_cnt_d = sbe_cnt_q + c_cnt_one;
      end
      if (w_out_fire && s2_dbe_q && (dbe_cnt_q != c_cnt_max)) begin
        dbe_cnt_d = dbe_cnt_q + c_cnt_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {DATA_W{1'b0}};
      s1_syn_q   <= {HC{1'b0}};
      s1_par_q   <= 1'b0;
      s1_corr_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= {DATA_W{1'b0}};
      s2_sbe_q   <= 1'b0;
      s2_dbe_q   <= 1'b0;
      s2_syn_q   <= {HC{1'b0}};
      sbe_cnt_q  <= {CNT_W{1'b0}};
      dbe_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      s1_corr_q  <= s1_corr_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sbe_q   <= s2_sbe_d;
      s2_dbe_q   <= s2_dbe_d;
      s2_syn_q   <= s2_syn_d;
      sbe_cnt_q  <= sbe_cnt_d;
      dbe_cnt_q  <= dbe_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sbe   = s2_sbe_q;
  assign out_dbe   = s2_dbe_q;
  assign out_syn   = s2_syn_q;
  assign sbe_cnt   = sbe_cnt_q;
  assign dbe_cnt   = dbe_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ecc_secded_pipe
//  Purpose  : Scoreboard bench for ecc_secded_pipe (DATA_W=32, CHK_W=7,
//             CNT_W=4). A driver pushes expected responses from a codeword-
//             level reference model; an independent monitor pops and compares
//             on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ecc_secded_pipe;

  localparam int DW   = 32;
  localparam int CW   = 7;
  localparam int NW   = 4;
  localparam int NPOS = DW + CW - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [CW-1:0]   in_chk;
  logic            corr_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sbe;
  logic            out_dbe;
  logic [CW-2:0]   out_syn;
  logic            cnt_clr;
  logic [NW-1:0]   sbe_cnt;
  logic [NW-1:0]   dbe_cnt;
`ifdef ECC_ERR_INJECT_EN
  logic            inj_en   = 1'b0;
  logic [DW+CW-1:0] inj_mask = '0;
`endif

  always #5 clk = ~clk;

  ecc_secded_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_chk(in_chk), .corr_en(corr_en),
`ifdef ECC_ERR_INJECT_EN
    .inj_en(inj_en), .inj_mask(inj_mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sbe(out_sbe), .out_dbe(out_dbe), .out_syn(out_syn),
    .cnt_clr(cnt_clr), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          sbe;
    logic          dbe;
    logic [CW-2:0] syn;
    bit            lat;
    int            acc;
  } exp_t;

  exp_t exq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   bp_mode = 0;      // 0: always ready, 1: random stalls, 2: manual
  logic [NW-1:0] m_sbe = '0;
  logic [NW-1:0] m_dbe = '0;

  // Codeword tables: dpos[j] = position of data bit j; bitof[p] = index into
  // the received vector {chk, data} of the bit at position p (0 = overall).
  int dpos  [DW];
  int bitof [0:NPOS];

  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input bit corr);
    exp_t          e;
    logic [DW+CW-1:0] w;
    int            syn;
    int            par;
    w   = {c, d};
    syn = 0;
    par = 0;
    for (int p = 0; p <= NPOS; p++) begin
      if (w[bitof[p]]) begin
        par = par ^ 1;
        syn = syn ^ p;
      end
    end
    e.d   = d;
    e.sbe = 1'b0;
    e.dbe = 1'b0;
    e.syn = syn[CW-2:0];
    e.lat = 1'b0;
    e.acc = 0;
    if (par == 0 && syn == 0) begin
      // clean
    end else if (par == 1 && syn <= NPOS) begin
      e.sbe = 1'b1;
      if (corr && syn > 0 && bitof[syn] < DW) e.d[bitof[syn]] = ~e.d[bitof[syn]];
    end else begin
      e.dbe = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    int            s;
    logic [CW-1:0] c;
    s = 0;
    for (int j = 0; j < DW; j++) if (d[j]) s = s ^ dpos[j];
    c[CW-2:0] = s[CW-2:0];
    c[CW-1]   = ^{d, c[CW-2:0]};
    return c;
  endfunction

  task automatic rand_word(input int nerr, output logic [DW-1:0] d,
                           output logic [CW-1:0] c);
    logic [DW-1:0]    d0;
    logic [DW+CW-1:0] w;
    bit               used [0:NPOS];
    int               p;
    d0 = $urandom;
    w  = {encode(d0), d0};
    for (int i = 0; i <= NPOS; i++) used[i] = 1'b0;
    for (int n = 0; n < nerr; n++) begin
      p = $urandom_range(0, NPOS);
      while (used[p]) p = $urandom_range(0, NPOS);
      used[p] = 1'b1;
      w[bitof[p]] = ~w[bitof[p]];
    end
    d = w[DW-1:0];
    c = w[DW+CW-1:DW];
  endtask

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    if (bp_mode == 0)      out_ready = 1'b1;
    else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit corr);
    int   guard;
    exp_t e;
    guard = 0;
    step();
    in_valid = 1'b1; in_data = d; in_chk = c; corr_en = corr; cnt_clr = 1'b0;
    #1;
    while (!in_ready) begin
      guard++;
      if (guard > 200) begin
        errors++; checks++;
        $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
        in_valid = 1'b0;
        return;
      end
      step();
      #1;
    end
    e     = model(d, c, corr);
    e.lat = (bp_mode == 0);
    e.acc = cyc;
    exq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    bp_mode = 0;
    do begin
      step(); in_valid = 1'b0; cnt_clr = 1'b0; #1; g++;
    end while ((exq.size() != 0 || out_valid) && g < 400);
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words outstanding, required 0", exq.size());
      exq.delete();
    end
  endtask

  task automatic send_rand(input int nerr);
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    rand_word(nerr, d, c);
    send(d, c, $urandom_range(0, 1) == 1);
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  bit            prev_hold = 1'b0;
  bit            head_seen = 1'b0;
  logic [DW-1:0] h_data;
  logic          h_sbe, h_dbe;
  logic [CW-2:0] h_syn;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_hold = 1'b0;
      head_seen = 1'b0;
    end else begin
      checks++;
      if (sbe_cnt !== m_sbe || dbe_cnt !== m_dbe) begin
        errors++;
        $display("FAIL counters: sbe_cnt=%0d dbe_cnt=%0d, required %0d %0d",
                 sbe_cnt, dbe_cnt, m_sbe, m_dbe);
      end
      if (prev_hold) begin
        checks++;
        if (!out_valid || out_data !== h_data || out_sbe !== h_sbe ||
            out_dbe !== h_dbe || out_syn !== h_syn) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h sbe=%b dbe=%b syn=%0d, required 1 %h %b %b %0d",
                   out_valid, out_data, out_sbe, out_dbe, out_syn, h_data, h_sbe, h_dbe, h_syn);
        end
      end
      if (out_valid) begin
        if (exq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious: out_valid=1 data=%h with no word expected", out_data);
        end else begin
          if (!head_seen && exq[0].lat) begin
            checks++;
            if (cyc - exq[0].acc != 2) begin
              errors++;
              $display("FAIL latency: %0d cycles, required 2", cyc - exq[0].acc);
            end
          end
          head_seen = 1'b1;
          if (out_ready) begin
            e = exq.pop_front();
            head_seen = 1'b0;
            checks++;
            if (out_data !== e.d || out_sbe !== e.sbe || out_dbe !== e.dbe || out_syn !== e.syn) begin
              errors++;
              $display("FAIL word: data=%h sbe=%b dbe=%b syn=%0d, required data=%h sbe=%b dbe=%b syn=%0d",
                       out_data, out_sbe, out_dbe, out_syn, e.d, e.sbe, e.dbe, e.syn);
            end
            if (!cnt_clr) begin
              if (e.sbe && m_sbe != '1) m_sbe = m_sbe + 1'b1;
              if (e.dbe && m_dbe != '1) m_dbe = m_dbe + 1'b1;
            end
          end
        end
      end
      if (cnt_clr) begin
        m_sbe = '0;
        m_dbe = '0;
      end
      prev_hold = out_valid && !out_ready;
      h_data = out_data; h_sbe = out_sbe; h_dbe = out_dbe; h_syn = out_syn;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int k;
    int g;
    k = 0;
    bitof[0] = DW + CW - 1;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) == 0) begin
        for (int i = 0; i < CW - 1; i++) if (p == (1 << i)) bitof[p] = DW + i;
      end else begin
        dpos[k]  = p;
        bitof[p] = k;
        k++;
      end
    end

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chk = '0;
    corr_en = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sbe !== 1'b0 || out_dbe !== 1'b0 ||
        out_syn !== '0 || sbe_cnt !== '0 || dbe_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h sbe=%b dbe=%b syn=%0d cnt=%0d/%0d, required all 0",
               out_valid, out_data, out_sbe, out_dbe, out_syn, sbe_cnt, dbe_cnt);
    end
    rst_n = 1'b1;
    step(); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end

    // Directed words
    bp_mode = 0;
    send(32'h0000_0000, 7'h00, 1'b1);   // clean
    send(32'h0000_0001, 7'h00, 1'b1);   // data[0] error, corrected
    send(32'h0000_0001, 7'h00, 1'b0);   // same, raw
    send(32'h0000_0003, 7'h00, 1'b1);   // double error, syn 6
    send(32'h0000_0000, 7'h40, 1'b1);   // overall parity bit only
    send(32'h0000_0008, 7'h60, 1'b1);   // triple error, syn 39 out of range
    send(32'h0000_0000, 7'h04, 1'b1);   // check-bit position 4 error
    drain();

    // Backpressure: capacity 2, third word held off
    bp_mode = 2;
    step(); out_ready = 1'b0;
    send(32'hA5A5_0001, encode(32'hA5A5_0001), 1'b1);
    send(32'h5A5A_0002, encode(32'h5A5A_0002) ^ 7'h01, 1'b1);
    repeat (3) begin
      step();
      in_valid = 1'b1; in_data = 32'h1234_5678; in_chk = encode(32'h1234_5678); corr_en = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_ready: in_ready=%b with 2 words stalled, required 0", in_ready);
      end
    end
    bp_mode = 0;
    send(32'h1234_5678, encode(32'h1234_5678), 1'b1);
    drain();

    // Counters: saturate, then clear racing an increment
    step(); cnt_clr = 1'b1;
    step(); cnt_clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) send_rand(1);
    drain();
    checks++;
    if (sbe_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sbe_saturate: sbe_cnt=%0d, required 15", sbe_cnt);
    end
    bp_mode = 2;
    step(); out_ready = 1'b0;
    send_rand(1);
    g = 0;
    do begin step(); in_valid = 1'b0; #1; g++; end while (!out_valid && g < 20);
    step(); out_ready = 1'b1; cnt_clr = 1'b1;
    step(); cnt_clr = 1'b0;
    #1;
    checks++;
    if (sbe_cnt !== '0) begin
      errors++;
      $display("FAIL clr_priority: sbe_cnt=%0d, required 0", sbe_cnt);
    end
    drain();

    // Random traffic with random stalls
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_rand($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    for (int i = 0; i < 40; i++) send_rand($urandom_range(0, 2));
    drain();

    // Reset with two words in flight
    bp_mode = 2;
    step(); out_ready = 1'b0;
    send_rand(1);
    send_rand(0);
    step(); in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sbe_cnt !== '0 || dbe_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b cnt=%0d/%0d, required 0", out_valid, sbe_cnt, dbe_cnt);
    end
    exq.delete();
    m_sbe = '0;
    m_dbe = '0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    bp_mode = 0;
    idle(6);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush: out_valid=%b after reset release, required 0", out_valid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined single-error-correct / double-error-detect (SEC-DED) Hamming decoder.
- Successor to the team's flat 32-bit combinational SEC corrector. Adds configurable data width, an overall-parity bit for double-error detection, a 2-stage registered pipeline with valid/ready flow control, and saturating error counters.
- Sits on the read-return path of protected memories, between the SRAM macro and the consumer.

Parameters:
- DATA_W, 32, data bits per word. Legal values: 8, 16, 32, 64.
- CHK_W, 7, check bits per word, including the overall parity bit. Must satisfy 2^(CHK_W-1) >= DATA_W+CHK_W. Pairs used: 8/5, 16/6, 32/7, 64/8.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word.
- in_data  in  DATA_W  received data bits.
- in_chk  in  CHK_W  received check bits. Bit i < CHK_W-1 is the Hamming bit at codeword position 2^i. Bit CHK_W-1 is overall parity.
- corr_en  in  1  1 = apply correction; 0 = pass data raw but still flag errors.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  corrected (or raw) data.
- out_sbe  out  1  single-bit error detected.
- out_dbe  out  1  uncorrectable error detected.
- out_syn  out  CHK_W-1  Hamming syndrome (error position; 0 = none, or overall-parity bit).
- cnt_clr  in  1  synchronous clear of both counters.
- sbe_cnt  out  CNT_W  saturating count of delivered single-bit-error words.
- dbe_cnt  out  CNT_W  saturating count of delivered uncorrectable words.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids = 0; out_data, out_sbe, out_dbe, out_syn, sbe_cnt, dbe_cnt = 0. in_ready = 1 from the first cycle after release.

Codeword layout:
- Positions 1..DATA_W+CHK_W-1.
- Check bits sit at the power-of-two positions.
- Data bit j fills the j-th non-power-of-two position in ascending order. Example: data[0] -> position 3, data[1] -> position 5.

Stage 1 (registered):
- syn = XOR of the position indices of all set codeword bits.
- par = XOR of all DATA_W+CHK_W received bits.
- Data, syn, par and corr_en are captured.

Stage 2 (registered) classification:
- syn=0, par=0: clean. sbe=0, dbe=0.
- par=1, syn=0: overall-parity bit in error. sbe=1; data unchanged.
- par=1, 0 < syn <= DATA_W+CHK_W-1: sbe=1. If corr_en=1, flip the data bit at position syn; a check-bit position leaves data unchanged.
- par=1, syn > DATA_W+CHK_W-1: dbe=1; data raw.
- par=0, syn != 0: dbe=1; data raw.
- sbe and dbe are never both 1.

Latency and flow control:
- Latency is 2 cycles from input accept to out_valid with no backpressure. Throughput is 1 word/cycle.
- Each stage advances when it is empty or the downstream stage advances.
- in_ready = !s1_valid | s2_advance.
- out_valid, out_data, out_sbe, out_dbe and out_syn hold stable while out_valid=1 and out_ready=0.
- Pipeline capacity is 2 words. No word is dropped or duplicated.

Counters:
- Update on an output handshake (out_valid & out_ready) with the corresponding flag set.
- Saturate at 2^CNT_W-1; no wrap.
- cnt_clr has priority over a simultaneous increment; the result is 0.
- Counters are unaffected by corr_en.

Other rules:
- corr_en is sampled with the word at stage-1 capture. Changing it mid-flight does not affect words already in the pipe.
- Reset asserted mid-operation flushes all in-flight words; nothing appears after release.

Optional Feature:
- Macro: ECC_ERR_INJECT_EN.
- Defined: adds input ports inj_en (1) and inj_mask (DATA_W+CHK_W). The mask is XORed onto {in_chk, in_data} before stage 1 when inj_en=1 at input accept. It exists for in-system ECC path testing.
- Undefined: the ports are absent and the input path is unmodified.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- DATA_W=32, CHK_W=7, data=0, chk=0, corr_en=1 -> 2 cycles later out_data=0x00000000, sbe=0, dbe=0, syn=0.
- Same word with in_data[0] flipped (0x00000001) -> out_data=0x00000000, sbe=1, syn=3. Repeat with corr_en=0 -> out_data=0x00000001, sbe=1.
- in_data=0x00000003 (two errors, positions 3 and 5), chk=0 -> dbe=1, syn=6, out_data=0x00000003, sbe=0.
- chk=0x40 (overall parity only), data=0 -> sbe=1, syn=0, out_data=0.
- Hold out_ready=0 and offer 3 consecutive words -> first 2 accepted, in_ready=0 on the third; outputs stable. Release out_ready -> words delivered in order, 1 per cycle, none lost.
- CNT_W=4, deliver 20 single-error words -> sbe_cnt=15. Assert cnt_clr in the same cycle as a 21st single-error delivery -> sbe_cnt=0.
- Assert rst_n low with 2 words in flight -> out_valid=0 immediately; nothing emitted after release.
